pin_output_scheduler: RTL and testbench
=======================================

PIN_OUTPUT_SCHEDULER -- requirements
Module: pin_output_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the number of GPIO pins.
REQ-002 The block SHALL have parameter CORES, default 4, meaning the number of requesting cores (power of two, 2..8).
REQ-003 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port cfg_we  input  1  mask-table write strobe.
REQ-006 The block SHALL have port cfg_sel  input  clog2(CORES)  core index for the mask write.
REQ-007 The block SHALL have port cfg_mask  input  WIDTH  pin-ownership mask to write.
REQ-008 The block SHALL have port req  input  CORES  per-core output-update request.
REQ-009 The block SHALL have port req_data  input  CORES*WIDTH  packed data per core, core i in bits [i*WIDTH +: WIDTH], LSB-aligned.
REQ-010 The block SHALL have port grant  output  CORES  one-hot, combinational, the core serviced this cycle.
REQ-011 The block SHALL have port pins_out  output  WIDTH  registered pin output values.
REQ-012 The block SHALL have port pins_oe  output  WIDTH  registered output enable, OR of all core masks.
REQ-013 The block SHALL have port err_clr  input  1  clears the sticky overlap error.
REQ-014 The block SHALL have port overlap_err  output  1  sticky flag, a rejected overlapping mask write occurred.

Function
REQ-015 The block SHALL hold a mask table of CORES entries of WIDTH bits.
REQ-016 Arbitration SHALL be round-robin: a priority pointer rr (0..CORES-1) is kept; the first requesting core at or after rr, wrapping from CORES-1 to 0, is granted.
REQ-017 At most one grant bit SHALL be high per cycle; grant SHALL be all-zero when req is zero.
REQ-018 On a grant to core g, rr SHALL become (g+1) mod CORES at the next edge; with no grant, rr SHALL hold.
REQ-019 The granted data SHALL be scattered by the shared decompress datapath: the k-th LSB of req_data[g] goes to the k-th set bit of mask[g], counted from bit 0.
REQ-020 On the edge after a grant, pins_out SHALL become (pins_out & ~mask[g]) | scattered; pins outside mask[g] are unchanged (latency 1 cycle).
REQ-021 A cfg_we write SHALL be accepted only if cfg_mask & mask[j] == 0 for every j != cfg_sel; if accepted, mask[cfg_sel] updates at the next edge.
REQ-022 A rejected write SHALL leave the table unchanged and set overlap_err at the next edge.
REQ-023 pins_oe SHALL equal the OR of the mask table, updated on the edge after an accepted write.
REQ-024 Grant in the same cycle as a write to the same core SHALL use the old mask; the new mask applies from the next cycle.
REQ-025 When a mask bit is removed by a write, the corresponding pins_out bit SHALL hold its value (pins_oe drops).
REQ-026 err_clr SHALL clear overlap_err at the next edge; simultaneous err_clr and a rejected write SHALL leave overlap_err set.
REQ-027 A core with an all-zero mask MAY be granted; pins_out SHALL be unchanged.

Reset
REQ-028 While rst_n is low: mask table, pins_out, pins_oe, rr and overlap_err SHALL be 0, asynchronously.
REQ-029 The first edge after rst_n rises SHALL operate normally; a reset mid-request SHALL discard that update.

Structure
REQ-030 Default WIDTH, CORES and the derived clog2(CORES) index width SHALL be in the shared parameter header used by the GPIO blocks.
REQ-031 Exactly one pin_decompress instance SHALL be used, fed by a mux selected by the grant; no per-core copies.

Verification
REQ-032 Reset, write mask[0]=16'h5145, req[0] with data 16'h000B -> grant=0001, pins_out=16'h0105 one cycle later, pins_oe=16'h5145.
REQ-033 rr=0, req=4'b1111 held for 5 cycles -> grant sequence 0001,0010,0100,1000,0001.
REQ-034 mask[1]=16'h00F0 set, write mask[2]=16'h0180 -> table unchanged, overlap_err=1; err_clr -> 0; write 16'h0F00 -> accepted, pins_oe=16'h0FF0.
REQ-035 mask[0]=16'h000F, mask[1]=16'h00F0, pins_out=16'h00FF, core 1 writes data 0 -> pins_out=16'h000F.
REQ-036 Grant to core 0 with simultaneous write mask[0]=16'h00F0 -> old mask used this cycle, new mask on next grant.
REQ-037 rst_n low mid-sequence -> all outputs 0 immediately, next grant starts at core 0.

Source files
------------

// File: rtl/pin_output_scheduler_pkg.sv
// Shared GPIO parameter header: default pin count, core count and the derived
// core-index width used by the GPIO output blocks.
package pin_output_scheduler_pkg;

  localparam int GPIO_WIDTH = 16;
  localparam int GPIO_CORES = 4;
  localparam int GPIO_SEL_W = $clog2(GPIO_CORES);

endpackage

// File: rtl/pin_decompress.sv
// Bit-scatter (deposit) unit: the k-th LSB of data_in lands on the k-th set
// bit of mask_in, counted from bit 0; pins outside the mask read as zero.
module pin_decompress #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] mask_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] src;

  // Shift the source down each time a mask bit consumes its LSB.
  always_comb begin
    data_out = '0;
    src      = data_in;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask_in[i]) begin
        data_out[i] = src[0];
        src         = src >> 1;
      end
    end
  end

endmodule

// File: rtl/pin_output_scheduler.sv
// Round-robin scheduler that lets several cores update disjoint slices of a
// shared GPIO output register through one scatter datapath.
module pin_output_scheduler
  import pin_output_scheduler_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH,
  parameter int CORES = GPIO_CORES,
  localparam int SEL_W = $clog2(CORES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic [WIDTH-1:0]       cfg_mask,
  input  logic [CORES-1:0]       req,
  input  logic [CORES*WIDTH-1:0] req_data,
  output logic [CORES-1:0]       grant,
  output logic [WIDTH-1:0]       pins_out,
  output logic [WIDTH-1:0]       pins_oe,
  input  logic                   err_clr,
  output logic                   overlap_err
);

  logic [WIDTH-1:0] mask_q [CORES];
  logic [WIDTH-1:0] mask_d [CORES];
  logic [WIDTH-1:0] pins_out_q, pins_out_d;
  logic [WIDTH-1:0] pins_oe_q, pins_oe_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] cand_idx [CORES];
  logic [WIDTH-1:0] core_data [CORES];
  logic [CORES-1:0] clash;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] sel_data, sel_mask, scattered;
  logic             wr_ok, wr_rej;

  genvar gi;
  generate
    for (gi = 0; gi < CORES; gi++) begin : g_core
      // CORES is a power of two, so the index wraps naturally.
      assign cand_idx[gi]  = rr_q + SEL_W'(gi);
      assign core_data[gi] = req_data[gi*WIDTH +: WIDTH];
      assign clash[gi]     = (SEL_W'(gi) != cfg_sel) && (|(cfg_mask & mask_q[gi]));
      assign grant[gi]     = gnt_any && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < CORES; off++) begin
      if (!gnt_any && req[cand_idx[off]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx[off];
      end
    end
  end

  // Single shared scatter unit fed by the granted core's data and current mask.
  assign sel_data = core_data[gnt_idx];
  assign sel_mask = mask_q[gnt_idx];

  pin_decompress #(
    .WIDTH (WIDTH)
  ) u_decompress (
    .data_in  (sel_data),
    .mask_in  (sel_mask),
    .data_out (scattered)
  );

  assign wr_ok  = cfg_we && !(|clash);
  assign wr_rej = cfg_we && (|clash);

  always_comb begin
    mask_d = mask_q;
    if (wr_ok) begin
      mask_d[cfg_sel] = cfg_mask;
    end

    pins_oe_d = '0;
    for (int j = 0; j < CORES; j++) begin
      pins_oe_d = pins_oe_d | mask_d[j];
    end

    // The old mask is used here even when the same core is rewritten this cycle.
    pins_out_d = pins_out_q;
    rr_d       = rr_q;
    if (gnt_any) begin
      pins_out_d = (pins_out_q & ~sel_mask) | scattered;
      rr_d       = gnt_idx + SEL_W'(1);
    end

    err_d = err_q;
    if (wr_rej) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < CORES; j++) begin
        mask_q[j] <= '0;
      end
      pins_out_q <= '0;
      pins_oe_q  <= '0;
      rr_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int j = 0; j < CORES; j++) begin
        mask_q[j] <= mask_d[j];
      end
      pins_out_q <= pins_out_d;
      pins_oe_q  <= pins_oe_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
    end
  end

  assign pins_out    = pins_out_q;
  assign pins_oe     = pins_oe_q;
  assign overlap_err = err_q;

endmodule

// File: tb/tb_pin_output_scheduler.sv
// Directed bench for pin_output_scheduler: arbitration order, scatter results,
// mask ownership checks, error flag and asynchronous reset behaviour.
module tb_pin_output_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_mask;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic [15:0] pins_out;
  logic [15:0] pins_oe;
  logic        err_clr;
  logic        overlap_err;

  int checks = 0;
  int passed = 0;

  pin_output_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_mask    (cfg_mask),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .pins_out    (pins_out),
    .pins_oe     (pins_oe),
    .err_clr     (err_clr),
    .overlap_err (overlap_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_mask(input logic [1:0] sel, input logic [15:0] m);
    cfg_we = 1'b1; cfg_sel = sel; cfg_mask = m;
    step();
    cfg_we = 1'b0;
    $display("write mask[%0d]=%h -> pins_oe=%h err=%b", sel, m, pins_oe, overlap_err);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; req = '0; cfg_we = 1'b0; err_clr = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (pins_out !== 16'h0000) $display("FAIL reset_pins_out: got %h expected 0000", pins_out); else passed++;
    checks++; if (pins_oe !== 16'h0000) $display("FAIL reset_pins_oe: got %h expected 0000", pins_oe); else passed++;
    checks++; if (overlap_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", overlap_err); else passed++;
    checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant); else passed++;
    $display("reset: pins_out=%h pins_oe=%h err=%b grant=%b", pins_out, pins_oe, overlap_err, grant);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    write_mask(2'd0, 16'h5145);
    checks++; if (pins_oe !== 16'h5145) $display("FAIL basic_oe: got %h expected 5145", pins_oe); else passed++;
    req = 4'b0001; req_data = 64'h000B;
    #1;
    checks++; if (grant !== 4'b0001) $display("FAIL basic_grant: got %b expected 0001", grant); else passed++;
    step();
    req = '0;
    checks++; if (pins_out !== 16'h0105) $display("FAIL basic_pins: got %h expected 0105", pins_out); else passed++;
    $display("basic: grant core0 data 000B -> pins_out=%h", pins_out);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    pulse_reset();
    req = 4'b1111; req_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (grant !== exp_seq[c]) $display("FAIL rr_grant%0d: got %b expected %b", c, grant, exp_seq[c]); else passed++;
      $display("rr cycle %0d: grant=%b", c, grant);
      step();
    end
    req = '0;
    checks++; if (pins_out !== 16'h0000) $display("FAIL rr_zero_mask_pins: got %h expected 0000", pins_out); else passed++;
  endtask

  task automatic test_overlap();
    pulse_reset();
    write_mask(2'd1, 16'h00F0);
    checks++; if (pins_oe !== 16'h00F0) $display("FAIL ovl_first_oe: got %h expected 00F0", pins_oe); else passed++;
    write_mask(2'd2, 16'h0180);
    checks++; if (overlap_err !== 1'b1) $display("FAIL ovl_err_set: got %b expected 1", overlap_err); else passed++;
    checks++; if (pins_oe !== 16'h00F0) $display("FAIL ovl_oe_kept: got %h expected 00F0", pins_oe); else passed++;
    // Core 2 must still own no pins, so its update changes nothing.
    req = 4'b0100; req_data = 64'h0000_FFFF_0000_0000; err_clr = 1'b1;
    step();
    req = '0; err_clr = 1'b0;
    checks++; if (pins_out !== 16'h0000) $display("FAIL ovl_table_unchanged: got %h expected 0000", pins_out); else passed++;
    checks++; if (overlap_err !== 1'b0) $display("FAIL ovl_err_clr: got %b expected 0", overlap_err); else passed++;
    write_mask(2'd2, 16'h0F00);
    checks++; if (pins_oe !== 16'h0FF0) $display("FAIL ovl_accept_oe: got %h expected 0FF0", pins_oe); else passed++;
    checks++; if (overlap_err !== 1'b0) $display("FAIL ovl_accept_err: got %b expected 0", overlap_err); else passed++;
    err_clr = 1'b1;
    write_mask(2'd3, 16'h0010);
    err_clr = 1'b0;
    checks++; if (overlap_err !== 1'b1) $display("FAIL ovl_clr_vs_reject: got %b expected 1", overlap_err); else passed++;
  endtask

  task automatic test_masked_update();
    pulse_reset();
    write_mask(2'd0, 16'h000F);
    write_mask(2'd1, 16'h00F0);
    req = 4'b0011; req_data = 64'h0000_0000_000F_000F;
    step();
    checks++; if (pins_out !== 16'h000F) $display("FAIL mu_core0: got %h expected 000F", pins_out); else passed++;
    step();
    checks++; if (pins_out !== 16'h00FF) $display("FAIL mu_core1: got %h expected 00FF", pins_out); else passed++;
    req = 4'b0010; req_data = 64'h0;
    #1;
    checks++; if (grant !== 4'b0010) $display("FAIL mu_wrap_grant: got %b expected 0010", grant); else passed++;
    step();
    req = '0;
    checks++; if (pins_out !== 16'h000F) $display("FAIL mu_core1_zero: got %h expected 000F", pins_out); else passed++;
    $display("masked update: pins_out=%h", pins_out);
  endtask

  task automatic test_same_cycle_write();
    pulse_reset();
    write_mask(2'd0, 16'h000F);
    req = 4'b0001; req_data = 64'h0005;
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_mask = 16'h00F0;
    #1;
    checks++; if (grant !== 4'b0001) $display("FAIL sc_grant: got %b expected 0001", grant); else passed++;
    step();
    cfg_we = 1'b0;
    checks++; if (pins_out !== 16'h0005) $display("FAIL sc_old_mask: got %h expected 0005", pins_out); else passed++;
    checks++; if (pins_oe !== 16'h00F0) $display("FAIL sc_new_oe: got %h expected 00F0", pins_oe); else passed++;
    req_data = 64'h000A;
    step();
    req = '0;
    checks++; if (pins_out !== 16'h00A5) $display("FAIL sc_new_mask: got %h expected 00A5", pins_out); else passed++;
    $display("same-cycle write: pins_out=%h pins_oe=%h", pins_out, pins_oe);
  endtask

  task automatic test_reset_mid();
    write_mask(2'd1, 16'h00F0);
    checks++; if (overlap_err !== 1'b1) $display("FAIL rm_err_pre: got %b expected 1", overlap_err); else passed++;
    req = 4'b1111; req_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++; if (grant !== 4'b0010) $display("FAIL rm_grant_pre: got %b expected 0010", grant); else passed++;
    step();
    req = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pins_out !== 16'h0000) $display("FAIL rm_pins_async: got %h expected 0000", pins_out); else passed++;
    checks++; if (pins_oe !== 16'h0000) $display("FAIL rm_oe_async: got %h expected 0000", pins_oe); else passed++;
    checks++; if (overlap_err !== 1'b0) $display("FAIL rm_err_async: got %b expected 0", overlap_err); else passed++;
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    #1;
    checks++; if (grant !== 4'b0001) $display("FAIL rm_grant_post: got %b expected 0001", grant); else passed++;
    checks++; if (pins_out !== 16'h0000) $display("FAIL rm_pins_discarded: got %h expected 0000", pins_out); else passed++;
    req = '0;
    $display("reset mid-sequence: grant after reset=%b", grant);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_mask = '0;
    req = '0; req_data = '0; err_clr = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_overlap();
    test_masked_update();
    test_same_cycle_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
